// File: rtl/rv_pkg.sv
// Shared RISC-V core parameters and types used by the register-file
// writeback path.
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        WB_SRC_PIPE = 1'b0,
        WB_SRC_MC   = 1'b1
    } wb_src_e;

endpackage : rv_pkg

// File: rtl/regfile_scoreboard.sv
// Pending-destination scoreboard: one busy bit per architectural register,
// set at issue of a multi-cycle op and cleared when its result is written.
module regfile_scoreboard
    import rv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_valid,
    input  logic [REG_ADDR_W-1:0] set_rd,
    input  logic                  clr_valid,
    input  logic [REG_ADDR_W-1:0] clr_rd,
    input  logic [REG_ADDR_W-1:0] q_rs1,
    input  logic [REG_ADDR_W-1:0] q_rs2,
    output logic                  busy1,
    output logic                  busy2
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Next busy vector: clear first so a same-cycle set on the same rd wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_valid) begin
            busy_d[clr_rd] = 1'b0;
        end else begin
            busy_d = busy_d;
        end
        if (set_valid && (set_rd != {REG_ADDR_W{1'b0}})) begin
            busy_d[set_rd] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        busy_d[0] = 1'b0;
    end

    // Busy bit storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= {NUM_REGS{1'b0}};
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy1 = busy_q[q_rs1];
    assign busy2 = busy_q[q_rs2];

endmodule : regfile_scoreboard

// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter in front of the register file: port 0 (pipeline)
// has priority, port 1 (multi-cycle unit) is forced through after STARVE_LIMIT waits.
module regfile_wb_arbiter
    import rv_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb0_valid,
    output logic                  wb0_ready,
    input  logic [REG_ADDR_W-1:0] wb0_rd,
    input  logic [XLEN-1:0]       wb0_data,
    input  logic                  wb1_valid,
    output logic                  wb1_ready,
    input  logic [REG_ADDR_W-1:0] wb1_rd,
    input  logic [XLEN-1:0]       wb1_data,
    input  logic                  sb_set_valid,
    input  logic [REG_ADDR_W-1:0] sb_set_rd,
    input  logic [REG_ADDR_W-1:0] q_rs1,
    input  logic [REG_ADDR_W-1:0] q_rs2,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  write_en,
    output logic [REG_ADDR_W-1:0] a3,
    output logic [XLEN-1:0]       din
);

    localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  write_en_q, write_en_d;
    logic [REG_ADDR_W-1:0] a3_q, a3_d;
    logic [XLEN-1:0]       din_q, din_d;
    wb_src_e               src_q, src_d;
    logic                  force1;
    logic                  xfer0;
    logic                  xfer1;

    // Arbitration; nothing is acknowledged while reset is asserted.
    always_comb begin
        force1    = (cnt_q == LIMIT);
        wb0_ready = 1'b0;
        wb1_ready = 1'b0;
        if (rst) begin
            wb0_ready = 1'b0;
            wb1_ready = 1'b0;
        end else begin
            wb0_ready = wb0_valid && !force1;
            wb1_ready = wb1_valid && (!wb0_valid || force1);
        end
        xfer0 = wb0_valid && wb0_ready;
        xfer1 = wb1_valid && wb1_ready;
    end

    // Port-1 starvation counter, saturating at the limit.
    always_comb begin
        cnt_d = {CNT_W{1'b0}};
        if (wb1_valid && !wb1_ready) begin
            if (cnt_q == LIMIT) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Capture the winning transfer; x0 destinations complete but never write.
    always_comb begin
        write_en_d = 1'b0;
        a3_d       = a3_q;
        din_d      = din_q;
        src_d      = src_q;
        if (xfer1) begin
            write_en_d = (wb1_rd != {REG_ADDR_W{1'b0}});
            a3_d       = wb1_rd;
            din_d      = wb1_data;
            src_d      = WB_SRC_MC;
        end else if (xfer0) begin
            write_en_d = (wb0_rd != {REG_ADDR_W{1'b0}});
            a3_d       = wb0_rd;
            din_d      = wb0_data;
            src_d      = WB_SRC_PIPE;
        end else begin
            write_en_d = 1'b0;
        end
    end

    // State and write-port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= {CNT_W{1'b0}};
            write_en_q <= 1'b0;
            a3_q       <= {REG_ADDR_W{1'b0}};
            din_q      <= {XLEN{1'b0}};
            src_q      <= WB_SRC_PIPE;
        end else begin
            cnt_q      <= cnt_d;
            write_en_q <= write_en_d;
            a3_q       <= a3_d;
            din_q      <= din_d;
            src_q      <= src_d;
        end
    end

    assign write_en = write_en_q;
    assign a3       = a3_q;
    assign din      = din_q;

    // A port-1 result retires its pending bit in the cycle it hits the write port.
    regfile_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_valid (sb_set_valid),
        .set_rd    (sb_set_rd),
        .clr_valid (write_en_q && (src_q == WB_SRC_MC)),
        .clr_rd    (a3_q),
        .q_rs1     (q_rs1),
        .q_rs2     (q_rs2),
        .busy1     (busy1),
        .busy2     (busy2)
    );

endmodule : regfile_wb_arbiter

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive cycles port 1 may wait before it is forced to win.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous reset, active-high.
REQ-004 SHALL have ports wb0_valid in 1, wb0_ready out 1, wb0_rd in 5, wb0_data in 32: pipeline writeback requester.
REQ-005 SHALL have ports wb1_valid in 1, wb1_ready out 1, wb1_rd in 5, wb1_data in 32: multi-cycle unit (mul/div/load) writeback requester.
REQ-006 SHALL have ports sb_set_valid in 1, sb_set_rd in 5: marks a destination as pending on port 1 at issue.
REQ-007 SHALL have ports q_rs1 in 5, q_rs2 in 5, busy1 out 1, busy2 out 1: scoreboard queries for decode stall.
REQ-008 SHALL have ports write_en out 1, a3 out 5, din out 32: regfile write port.

Function
REQ-009 SHALL complete a transfer on port N when wbN_valid && wbN_ready; at most one port is ready per cycle.
REQ-010 SHALL give priority to port 0 by default: wb0_ready = wb0_valid && !force1; wb1_ready = wb1_valid && (!wb0_valid || force1).
REQ-011 SHALL hold a wait counter (width clog2(STARVE_LIMIT+1)): +1 each cycle wb1_valid && !wb1_ready, saturating at STARVE_LIMIT; cleared when port 1 transfers or wb1_valid is low.
REQ-012 SHALL assert force1 combinationally when counter == STARVE_LIMIT.
REQ-013 SHALL register the winning transfer: write_en, a3, din valid in the cycle after the handshake (latency 1); write_en = 0 when no transfer occurred.
REQ-014 SHALL complete handshakes with rd == 0 but drive write_en = 0 for them (x0 never written).
REQ-015 SHALL hold wbN_ready combinational from current inputs/state only; no dependency on write-port outputs.
REQ-016 SHALL keep 32 busy bits; bit 0 is constant 0.
REQ-017 SHALL set busy[sb_set_rd] on sb_set_valid when sb_set_rd != 0; no effect for rd 0.
REQ-018 SHALL clear busy[rd] when a port-1 transfer with that rd reaches the write port (the write_en cycle).
REQ-019 SHALL let set win when set and clear target the same rd in the same cycle (bit stays 1).
REQ-020 SHALL drive busy1 = busy[q_rs1], busy2 = busy[q_rs2] combinationally; x0 queries return 0.
REQ-021 SHALL treat port-0 writes as not affecting busy bits.
REQ-022 SHALL treat wbN_rd/wbN_data as don't-care when wbN_valid is low; requesters hold stable while valid && !ready.

Reset
REQ-023 SHALL on rst: write_en=0, a3=0, din=0, wait counter=0, all busy bits=0.
REQ-024 SHALL drop any transfer accepted in the reset cycle; handshakes are not acknowledged in a rst cycle (both ready = 0).
REQ-025 SHALL resume normal arbitration the first cycle after rst deasserts, no extra idle cycles.

Structure
REQ-026 SHALL take XLEN=32, REG_ADDR_W=5, NUM_REGS=32 and a wb_src_e enum {WB_SRC_PIPE, WB_SRC_MC} from shared package rv_pkg.
REQ-027 SHALL place busy bits, set/clear and query logic in one sub-module regfile_scoreboard; arbitration, counter and output register stay top-level.

Verification
REQ-028 SHALL cover: both valid, wb0 rd=5 data=0x11, wb1 rd=6 data=0x22 -> wb0 accepted cycle 0, write_en a3=5 din=0x11 cycle 1; wb1 waits.
REQ-029 SHALL cover: wb0_valid held high for 10 cycles, wb1_valid high, STARVE_LIMIT=4 -> wb1_ready in cycle 4, a3/din from wb1 in cycle 5, counter back to 0.
REQ-030 SHALL cover: sb_set rd=7; q_rs1=7 -> busy1=1 next cycle; wb1 transfer rd=7 -> busy1=0 the cycle after write_en.
REQ-031 SHALL cover: sb_set rd=9 in same cycle port-1 write of rd=9 hits write port -> busy[9] remains 1.
REQ-032 SHALL cover: wb0 rd=0 data=0xFFFFFFFF -> wb0_ready=1, write_en=0 next cycle; sb_set rd=0 -> busy1=0 for q_rs1=0.
REQ-033 SHALL cover: busy[3]=1, counter=2, rst pulsed one cycle with both valid -> both ready 0 in reset cycle, all outputs 0, busy[3]=0 after.
